lsu_hs: RTL and testbench

- Parametrised load/store unit for the L/S stage; replaces the DPI-backed, fixed-64-bit lsu.
- Accepts one load/store request from the pipeline and drives a valid/ready memory port with aligned address and per-byte write strobes.
- Waits a variable number of cycles for read data, then returns sign- or zero-extended load data on a one-cycle response pulse.
- Multi-cycle memory latency is supported (cache or bus behind it); one outstanding request at a time.

---
 rtl/lsu_hs.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_hs.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_hs.sv
// lsu_hs: parametrised load/store unit for the L/S pipeline stage.
//
// Takes one load/store request at a time from the pipeline. It drives a
// valid/ready memory port with an aligned address and per-byte write strobes.
// It waits for read data and returns extended load data on a one-cycle
// response pulse.
//
// Parameters:
//   XLEN   data/address width, 32 or 64
//   NB     bytes per memory word (derived)
//   OFS_W  byte-offset bits used for lane selection (derived)
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> a misaligned access responds with resp_err_o=1 and no memory request
//   undefined -> a misaligned access is silently aligned down to its natural size
//
// Ports:
//   clk_i, rst_ni                clock, synchronous active-low reset
//   req_valid_i / req_ready_o    pipeline request handshake
//   req_we_i                     1 = store, 0 = load
//   req_memop_i                  funct3 size/sign encoding
//   req_addr_i                   byte address
//   req_wdata_i                  right-justified store data
//   resp_valid_o                 one-cycle completion pulse
//   resp_rdata_o                 extended load data (0 for stores and errors)
//   resp_err_o                   illegal op or trapped misaligned access
//   mem_req_valid_o / mem_req_ready_i   memory request handshake
//   mem_we_o                     memory write request
//   mem_addr_o                   word-aligned address
//   mem_wdata_o                  store data shifted into its byte lanes
//   mem_wstrb_o                  per-byte write strobes
//   mem_rvalid_i, mem_rdata_i    read data return
module lsu_hs #(
  parameter  int XLEN  = 64,
  localparam int NB    = XLEN / 8,
  localparam int OFS_W = $clog2(XLEN / 8)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_memop_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [NB-1:0]   mem_wstrb_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e           state_q;
  logic             we_q;
  logic [2:0]       memop_q;
  logic [OFS_W-1:0] off_q;

  logic [OFS_W-1:0] req_off;
  logic [OFS_W-1:0] size_mask;
  logic [OFS_W-1:0] eff_off_d;
  logic             illegal_d;
  logic             trap_d;
  logic [NB-1:0]    strb_base;
  logic [NB-1:0]    strb_d;
  logic [XLEN-1:0]  wdata_d;
  logic [XLEN-1:0]  rshift;
  logic [XLEN-1:0]  rdata_d;

  // Request decode. size_mask covers the offset bits below the access size.
  // Clearing them gives the naturally aligned lane offset. Testing them
  // detects a misaligned access.
  always_comb begin
    req_off = req_addr_i[OFS_W-1:0];
    case (req_memop_i[1:0])
      2'b00:   size_mask = '0;
      2'b01:   size_mask = OFS_W'(1);
      2'b10:   size_mask = OFS_W'(3);
      default: size_mask = '1;
    endcase
    eff_off_d = req_off & ~size_mask;

    // Double-word ops and lwu only exist on a 64-bit datapath.
    illegal_d = (req_memop_i == 3'b111)
             || (req_we_i && req_memop_i[2])
             || ((XLEN == 32) && ((req_memop_i[1:0] == 2'b11) || (req_memop_i == 3'b110)));
`ifdef LSU_MISALIGN_TRAP_EN
    trap_d = illegal_d || ((req_off & size_mask) != '0);
`else
    trap_d = illegal_d;
`endif

    case (req_memop_i[1:0])
      2'b00:   strb_base = NB'(1);
      2'b01:   strb_base = NB'(3);
      2'b10:   strb_base = NB'(15);
      default: strb_base = '1;
    endcase
    strb_d  = strb_base << eff_off_d;
    wdata_d = req_wdata_i << {eff_off_d, 3'b000};
  end

  // Load path: move the addressed lane down to bit 0, then extend it by op.
  always_comb begin
    rshift = mem_rdata_i >> {off_q, 3'b000};
    case (memop_q)
      3'b000:  rdata_d = XLEN'($signed(rshift[7:0]));
      3'b001:  rdata_d = XLEN'($signed(rshift[15:0]));
      3'b010:  rdata_d = XLEN'($signed(rshift[31:0]));
      3'b100:  rdata_d = XLEN'(rshift[7:0]);
      3'b101:  rdata_d = XLEN'(rshift[15:0]);
      3'b110:  rdata_d = XLEN'(rshift[31:0]);
      default: rdata_d = rshift;
    endcase
  end

  // Control FSM. All outputs are registered. They change only on state
  // transitions, so the mem_* request stays stable while it is stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      memop_q         <= 3'b000;
      off_q           <= '0;
      req_ready_o     <= 1'b1;
      resp_valid_o    <= 1'b0;
      resp_err_o      <= 1'b0;
      resp_rdata_o    <= '0;
      mem_req_valid_o <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
      mem_wstrb_o     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            memop_q     <= req_memop_i;
            off_q       <= eff_off_d;
            req_ready_o <= 1'b0;
            if (trap_d) begin
              state_q      <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_rdata_o <= '0;
            end else begin
              state_q         <= REQ;
              mem_req_valid_o <= 1'b1;
              mem_we_o        <= req_we_i;
              mem_addr_o      <= {req_addr_i[XLEN-1:OFS_W], {OFS_W{1'b0}}};
              mem_wdata_o     <= req_we_i ? wdata_d : '0;
              mem_wstrb_o     <= req_we_i ? strb_d : '0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            mem_we_o        <= 1'b0;
            if (we_q) begin
              state_q      <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b0;
              resp_rdata_o <= '0;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state_q      <= RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= rdata_d;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_o <= 1'b0;
          resp_err_o   <= 1'b0;
          req_ready_o  <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_hs.sv
// tb_lsu_hs: directed self-checking bench for lsu_hs at XLEN=64.
// It drives requests and plays the memory side by hand. Each observed
// output is compared against a hand-computed constant.
// If LSU_MISALIGN_TRAP_EN is defined, the misaligned cases expect a trap.
module tb_lsu_hs;

   localparam int XLEN = 64;
   localparam int NB   = XLEN / 8;

   logic            clock = 1'b0;
   logic            resetN;
   logic            reqValid;
   logic            reqReady;
   logic            reqWe;
   logic [2:0]      reqMemop;
   logic [XLEN-1:0] reqAddr;
   logic [XLEN-1:0] reqWdata;
   logic            respValid;
   logic [XLEN-1:0] respRdata;
   logic            respErr;
   logic            memReqValid;
   logic            memReqReady;
   logic            memWe;
   logic [XLEN-1:0] memAddr;
   logic [XLEN-1:0] memWdata;
   logic [NB-1:0]   memWstrb;
   logic            memRvalid;
   logic [XLEN-1:0] memRdata;

   int totalChecks = 0;
   int badChecks   = 0;
   int cycleCount  = 0;
   int acceptCycle = 0;
   int memReqCount = 0;
   int respCount   = 0;

   lsu_hs #(.XLEN(XLEN)) dut (
      .clk_i           (clock),
      .rst_ni          (resetN),
      .req_valid_i     (reqValid),
      .req_ready_o     (reqReady),
      .req_we_i        (reqWe),
      .req_memop_i     (reqMemop),
      .req_addr_i      (reqAddr),
      .req_wdata_i     (reqWdata),
      .resp_valid_o    (respValid),
      .resp_rdata_o    (respRdata),
      .resp_err_o      (respErr),
      .mem_req_valid_o (memReqValid),
      .mem_req_ready_i (memReqReady),
      .mem_we_o        (memWe),
      .mem_addr_o      (memAddr),
      .mem_wdata_o     (memWdata),
      .mem_wstrb_o     (memWstrb),
      .mem_rvalid_i    (memRvalid),
      .mem_rdata_i     (memRdata)
   );

   // Free-running 100 MHz-style clock.
   always #5 clock = ~clock;

   // Counts cycles with a memory request or a response pulse, so tests can
   // confirm that traps never reach memory and that stores respond once.
   always @(posedge clock) begin
      if (memReqValid === 1'b1) memReqCount <= memReqCount + 1;
      if (respValid === 1'b1) respCount <= respCount + 1;
   end

   // Advance one cycle and settle just after the active edge.
   task automatic tick();
      @(posedge clock);
      #1;
      cycleCount++;
   endtask

   task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                              input logic [XLEN-1:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   // Present one request for a single cycle while the unit is idle.
   task automatic applyStimulus(input logic we, input logic [2:0] memop,
                                input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata,
                                input string tag);
      checkOutput({tag, " ready before"}, XLEN'(reqReady), XLEN'(1));
      reqValid = 1'b1;
      reqWe    = we;
      reqMemop = memop;
      reqAddr  = addr;
      reqWdata = wdata;
      tick();
      acceptCycle = cycleCount;
      reqValid    = 1'b0;
      checkOutput({tag, " busy"}, XLEN'(reqReady), XLEN'(0));
   endtask

   // Bounded wait for the response pulse. Latency counts the accept cycle as 1.
   task automatic waitResp(input string tag, output int lat);
      int n = 0;
      while (respValid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checkOutput({tag, " resp seen"}, XLEN'(respValid), XLEN'(1));
      lat = cycleCount - acceptCycle + 2;
   endtask

   task automatic doLoad(input logic [2:0] memop, input logic [XLEN-1:0] addr,
                         input logic [XLEN-1:0] rdata, input logic [XLEN-1:0] expAddr,
                         input logic [XLEN-1:0] expData, input string tag);
      int lat;
      memReqReady = 1'b1;
      applyStimulus(1'b0, memop, addr, '0, tag);
      checkOutput({tag, " addr"}, memAddr, expAddr);
      checkOutput({tag, " we"}, XLEN'(memWe), XLEN'(0));
      tick();
      memRvalid = 1'b1;
      memRdata  = rdata;
      tick();
      memRvalid = 1'b0;
      waitResp(tag, lat);
      checkOutput({tag, " latency"}, XLEN'(lat), XLEN'(4));
      checkOutput({tag, " rdata"}, respRdata, expData);
      checkOutput({tag, " err"}, XLEN'(respErr), XLEN'(0));
      tick();
      checkOutput({tag, " pulse end"}, XLEN'(respValid), XLEN'(0));
   endtask

   task automatic doStore(input logic [2:0] memop, input logic [XLEN-1:0] addr,
                          input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] expAddr,
                          input logic [NB-1:0] expStrb, input logic [XLEN-1:0] expWdata,
                          input string tag);
      int lat;
      memReqReady = 1'b1;
      applyStimulus(1'b1, memop, addr, wdata, tag);
      checkOutput({tag, " addr"}, memAddr, expAddr);
      checkOutput({tag, " we"}, XLEN'(memWe), XLEN'(1));
      checkOutput({tag, " strb"}, XLEN'(memWstrb), XLEN'(expStrb));
      checkOutput({tag, " wdata"}, memWdata, expWdata);
      waitResp(tag, lat);
      checkOutput({tag, " latency"}, XLEN'(lat), XLEN'(3));
      checkOutput({tag, " rdata"}, respRdata, '0);
      checkOutput({tag, " err"}, XLEN'(respErr), XLEN'(0));
      tick();
      checkOutput({tag, " pulse end"}, XLEN'(respValid), XLEN'(0));
   endtask

   // Requests that must be refused without touching memory.
   task automatic doTrap(input logic we, input logic [2:0] memop,
                         input logic [XLEN-1:0] addr, input string tag);
      int lat;
      int reqBefore;
      reqBefore   = memReqCount;
      memReqReady = 1'b1;
      applyStimulus(we, memop, addr, 64'hFFFF, tag);
      waitResp(tag, lat);
      checkOutput({tag, " latency"}, XLEN'(lat), XLEN'(2));
      checkOutput({tag, " err"}, XLEN'(respErr), XLEN'(1));
      checkOutput({tag, " rdata"}, respRdata, '0);
      tick();
      checkOutput({tag, " pulse end"}, XLEN'(respValid), XLEN'(0));
      checkOutput({tag, " no mem req"}, XLEN'(memReqCount), XLEN'(reqBefore));
   endtask

   // Main directed sequence.
   initial begin
      int lat;
      int respBefore;

      resetN      = 1'b0;
      reqValid    = 1'b0;
      reqWe       = 1'b0;
      reqMemop    = 3'b000;
      reqAddr     = '0;
      reqWdata    = '0;
      memReqReady = 1'b0;
      memRvalid   = 1'b0;
      memRdata    = '0;
      tick();
      tick();
      checkOutput("reset ready", XLEN'(reqReady), XLEN'(1));
      checkOutput("reset resp valid", XLEN'(respValid), XLEN'(0));
      checkOutput("reset resp err", XLEN'(respErr), XLEN'(0));
      checkOutput("reset resp rdata", respRdata, '0);
      checkOutput("reset mem valid", XLEN'(memReqValid), XLEN'(0));
      checkOutput("reset mem we", XLEN'(memWe), XLEN'(0));
      checkOutput("reset mem addr", memAddr, '0);
      checkOutput("reset mem wdata", memWdata, '0);
      checkOutput("reset mem wstrb", XLEN'(memWstrb), XLEN'(0));
      resetN = 1'b1;
      tick();

      // lb of byte 3. Spurious rvalid during the handshake cycle must be dropped.
      memReqReady = 1'b1;
      applyStimulus(1'b0, 3'b000, 64'h8000_0003, '0, "lb");
      checkOutput("lb mem valid", XLEN'(memReqValid), XLEN'(1));
      checkOutput("lb addr", memAddr, 64'h8000_0000);
      memRvalid = 1'b1;
      memRdata  = 64'h1111_1111_1111_1111;
      tick();
      checkOutput("lb mem valid drop", XLEN'(memReqValid), XLEN'(0));
      memRdata = 64'h0000_0000_80FF_0000;
      tick();
      memRvalid = 1'b0;
      waitResp("lb", lat);
      checkOutput("lb latency", XLEN'(lat), XLEN'(4));
      checkOutput("lb rdata", respRdata, 64'hFFFF_FFFF_FFFF_FF80);
      checkOutput("lb err", XLEN'(respErr), XLEN'(0));
      tick();
      checkOutput("lb pulse end", XLEN'(respValid), XLEN'(0));
      checkOutput("lb ready again", XLEN'(reqReady), XLEN'(1));

      // sh stalled by memory for three cycles; the request must hold still.
      respBefore  = respCount;
      memReqReady = 1'b0;
      applyStimulus(1'b1, 3'b001, 64'h8000_0006, 64'h1234, "sh");
      for (int i = 0; i < 3; i++) begin
         checkOutput("sh hold valid", XLEN'(memReqValid), XLEN'(1));
         checkOutput("sh hold we", XLEN'(memWe), XLEN'(1));
         checkOutput("sh hold addr", memAddr, 64'h8000_0000);
         checkOutput("sh hold strb", XLEN'(memWstrb), XLEN'(8'hC0));
         checkOutput("sh hold wdata", memWdata, 64'h1234_0000_0000_0000);
         checkOutput("sh no early resp", XLEN'(respValid), XLEN'(0));
         tick();
      end
      memReqReady = 1'b1;
      waitResp("sh", lat);
      checkOutput("sh latency", XLEN'(lat), XLEN'(6));
      checkOutput("sh err", XLEN'(respErr), XLEN'(0));
      tick();
      tick();
      checkOutput("sh single resp", XLEN'(respCount - respBefore), XLEN'(1));

      // mem_rvalid while idle must not produce a response.
      memRvalid = 1'b1;
      tick();
      checkOutput("idle rvalid ignored", XLEN'(respValid), XLEN'(0));
      memRvalid = 1'b0;

      // lwu with read data arriving several cycles after the handshake.
      memReqReady = 1'b1;
      applyStimulus(1'b0, 3'b110, 64'h8000_0004, '0, "lwu");
      tick();
      for (int i = 0; i < 4; i++) begin
         checkOutput("lwu wait ready", XLEN'(reqReady), XLEN'(0));
         checkOutput("lwu wait resp", XLEN'(respValid), XLEN'(0));
         tick();
      end
      memRvalid = 1'b1;
      memRdata  = 64'h8000_0001_DEAD_BEEF;
      tick();
      memRvalid = 1'b0;
      waitResp("lwu", lat);
      checkOutput("lwu latency", XLEN'(lat), XLEN'(8));
      checkOutput("lwu rdata", respRdata, 64'h0000_0000_8000_0001);
      tick();

      // Illegal ops: reserved memop 111 load, and a store with memop[2] set.
      doTrap(1'b0, 3'b111, 64'h8000_0000, "op111");
      doTrap(1'b1, 3'b100, 64'h8000_0000, "st100");

      // Reset mid-load abandons the transaction.
      memReqReady = 1'b1;
      applyStimulus(1'b0, 3'b011, 64'h8000_0008, '0, "rst");
      tick();
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      checkOutput("rst ready", XLEN'(reqReady), XLEN'(1));
      checkOutput("rst mem valid", XLEN'(memReqValid), XLEN'(0));
      checkOutput("rst mem addr", memAddr, '0);
      memRvalid = 1'b1;
      memRdata  = 64'h5555_5555_5555_5555;
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("rst no resp", XLEN'(respValid), XLEN'(0));
      end
      memRvalid = 1'b0;
      checkOutput("rst idle ready", XLEN'(reqReady), XLEN'(1));

      // Lane select and extension across sizes.
      doLoad(3'b001, 64'h8000_000A, 64'h0000_0000_9876_0000, 64'h8000_0008,
             64'hFFFF_FFFF_FFFF_9876, "lh");
      doLoad(3'b101, 64'h8000_000A, 64'h0000_0000_9876_0000, 64'h8000_0008,
             64'h0000_0000_0000_9876, "lhu");
      doLoad(3'b010, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'h8000_0000,
             64'hFFFF_FFFF_8765_4321, "lw");
      doLoad(3'b100, 64'h8000_0007, 64'hF100_0000_0000_0000, 64'h8000_0000,
             64'h0000_0000_0000_00F1, "lbu");
      doLoad(3'b011, 64'h8000_0010, 64'h8123_4567_89AB_CDEF, 64'h8000_0010,
             64'h8123_4567_89AB_CDEF, "ld");
      doStore(3'b000, 64'h8000_0005, 64'hAB, 64'h8000_0000, 8'h20,
              64'h0000_AB00_0000_0000, "sb");
      doStore(3'b010, 64'h8000_0004, 64'hCAFE_BABE, 64'h8000_0000, 8'hF0,
              64'hCAFE_BABE_0000_0000, "sw");
      doStore(3'b011, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h8000_0010, 8'hFF,
              64'h0123_4567_89AB_CDEF, "sd");

      // Misaligned accesses: trapped, or aligned down to the natural size.
`ifdef LSU_MISALIGN_TRAP_EN
      doTrap(1'b0, 3'b010, 64'h8000_0002, "lw mis");
      doTrap(1'b1, 3'b001, 64'h8000_0007, "sh mis");
`else
      doLoad(3'b010, 64'h8000_0002, 64'h1111_2222_F000_0004, 64'h8000_0000,
             64'hFFFF_FFFF_F000_0004, "lw mis");
      doStore(3'b001, 64'h8000_0007, 64'h1234, 64'h8000_0000, 8'hC0,
              64'h1234_0000_0000_0000, "sh mis");
`endif

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
